// File: rtl/axi4_lite_pkg.sv
// Shared types for the single-clock AXI4-Lite byte RAM slave.
// Response codes, FSM encodings and an index-width helper.
package axi4_lite_pkg;

  localparam logic [1:0] C_RESP_OKAY   = 2'b00;
  localparam logic [1:0] C_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_EXEC,
    W_RESP
  } wstate_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_READ,
    R_RESP
  } rstate_e;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/axi4_lite_dpram_lane.sv
// One byte lane of the RAM: read-first, AXI write/read plus processor port.
// AXI side has separate read and write addresses so both FSMs run freely.
module axi4_lite_dpram_lane
  import axi4_lite_pkg::*;
#(
  parameter int L_DEPTH_WORDS = 32
) (
  input  logic                            i_clk,
  input  logic                            i_a_we,
  input  logic [idx_w(L_DEPTH_WORDS)-1:0] i_a_waddr,
  input  logic [7:0]                      i_a_wdata,
  input  logic                            i_a_re,
  input  logic [idx_w(L_DEPTH_WORDS)-1:0] i_a_raddr,
  output logic [7:0]                      o_a_rdata,
  input  logic                            i_b_we,
  input  logic [idx_w(L_DEPTH_WORDS)-1:0] i_b_addr,
  input  logic [7:0]                      i_b_wdata,
  output logic [7:0]                      o_b_rdata
);

  logic [7:0] mem_q [L_DEPTH_WORDS];
  logic [7:0] a_rdata_q;
  logic [7:0] b_rdata_q;

  // Storage and registered reads; non-blocking writes give old data on reads.
  always_ff @(posedge i_clk) begin
    if (i_b_we) mem_q[i_b_addr] <= i_b_wdata;
    if (i_a_we) mem_q[i_a_waddr] <= i_a_wdata;
    if (i_a_re) a_rdata_q <= mem_q[i_a_raddr];
    b_rdata_q <= mem_q[i_b_addr];
  end

  assign o_a_rdata = a_rdata_q;
  assign o_b_rdata = b_rdata_q;

endmodule

// File: rtl/axi4_lite_slave_sc_dpram.sv
// AXI4-Lite slave over a 4-lane byte RAM shared with the 9x8 processor.
// AXI writes win byte collisions; processor sees bytes with 1-cycle reads.
module axi4_lite_slave_sc_dpram
  import axi4_lite_pkg::*;
#(
  parameter int L_ADDR_WIDTH  = 7,
  parameter int L_DEPTH_WORDS = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_axi_awvalid,
  output logic                    o_axi_awready,
  input  logic [L_ADDR_WIDTH-1:0] i_axi_awaddr,
  input  logic                    i_axi_wvalid,
  output logic                    o_axi_wready,
  input  logic [31:0]             i_axi_wdata,
  input  logic [3:0]              i_axi_wstrb,
  output logic                    o_axi_bvalid,
  input  logic                    i_axi_bready,
  output logic [1:0]              o_axi_bresp,
  input  logic                    i_axi_arvalid,
  output logic                    o_axi_arready,
  input  logic [L_ADDR_WIDTH-1:0] i_axi_araddr,
  output logic                    o_axi_rvalid,
  input  logic                    i_axi_rready,
  output logic [31:0]             o_axi_rdata,
  output logic [1:0]              o_axi_rresp,
  input  logic [L_ADDR_WIDTH-1:0] i_mc_addr,
  input  logic                    i_mc_wr,
  input  logic [7:0]              i_mc_wdata,
  output logic [7:0]              o_mc_rdata,
  output logic                    o_mc_axi_wr,
  output logic [L_ADDR_WIDTH-1:0] o_mc_axi_waddr,
  output logic                    o_mc_collision
);

  localparam int IW = idx_w(L_DEPTH_WORDS);
  localparam int WW = L_ADDR_WIDTH - 2;

  wstate_e     wstate_q;
  logic        awready_q, wready_q, bvalid_q;
  logic [1:0]  bresp_q;
  logic [WW-1:0] aw_word_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        mc_axi_wr_q;
  logic [L_ADDR_WIDTH-1:0] mc_axi_waddr_q;

  rstate_e     rstate_q;
  logic        arready_q, rvalid_q, rd_ok_q;
  logic [1:0]  rresp_q;
  logic [WW-1:0] ar_word_q;

  logic        mc_ok_q, mc_coll_q;
  logic [1:0]  mc_sel_q;

  logic        aw_hs, w_hs, ar_hs;
  logic        w_inrange, r_inrange, mc_inrange;
  logic        w_commit, r_re, mc_wr_ok, coll;
  logic [WW-1:0] mc_word;
  logic [31:0] a_rdata;
  logic [7:0]  b_rdata [4];
  logic        unused_addr_bits;

  assign aw_hs = i_axi_awvalid & awready_q;
  assign w_hs  = i_axi_wvalid & wready_q;
  assign ar_hs = i_axi_arvalid & arready_q;
  assign mc_word = i_mc_addr[L_ADDR_WIDTH-1:2];

  assign w_inrange  = 32'(aw_word_q) < 32'(L_DEPTH_WORDS);
  assign r_inrange  = 32'(ar_word_q) < 32'(L_DEPTH_WORDS);
  assign mc_inrange = 32'(mc_word) < 32'(L_DEPTH_WORDS);

  assign w_commit = (wstate_q == W_EXEC) & w_inrange & ~i_rst;
  assign r_re     = (rstate_q == R_READ) & r_inrange;
  assign mc_wr_ok = i_mc_wr & mc_inrange;
  assign coll     = mc_wr_ok & w_commit
                  & wstrb_q[i_mc_addr[1:0]]
                  & (mc_word == aw_word_q);

  assign unused_addr_bits = ^{i_axi_awaddr[1:0], i_axi_araddr[1:0]};

  // Write FSM: independent AW/W capture, one commit cycle, held response.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wstate_q       <= W_IDLE;
      awready_q      <= 1'b1;
      wready_q       <= 1'b1;
      bvalid_q       <= 1'b0;
      bresp_q        <= C_RESP_OKAY;
      mc_axi_wr_q    <= 1'b0;
      mc_axi_waddr_q <= '0;
    end else begin
      mc_axi_wr_q <= 1'b0;
      unique case (wstate_q)
        W_IDLE: begin
          if (aw_hs) begin
            aw_word_q <= i_axi_awaddr[L_ADDR_WIDTH-1:2];
            awready_q <= 1'b0;
          end
          if (w_hs) begin
            wdata_q  <= i_axi_wdata;
            wstrb_q  <= i_axi_wstrb;
            wready_q <= 1'b0;
          end
          if ((aw_hs | ~awready_q) & (w_hs | ~wready_q))
            wstate_q <= W_EXEC;
        end
        W_EXEC: begin
          bvalid_q    <= 1'b1;
          bresp_q     <= w_inrange ? C_RESP_OKAY : C_RESP_SLVERR;
          mc_axi_wr_q <= w_inrange;
          if (w_inrange) mc_axi_waddr_q <= {aw_word_q, 2'b00};
          wstate_q    <= W_RESP;
        end
        W_RESP: begin
          if (i_axi_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            wstate_q  <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // Read FSM: latch address, access RAM, hold response until rready.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rresp_q   <= C_RESP_OKAY;
      rd_ok_q   <= 1'b0;
    end else begin
      unique case (rstate_q)
        R_IDLE: begin
          if (ar_hs) begin
            ar_word_q <= i_axi_araddr[L_ADDR_WIDTH-1:2];
            arready_q <= 1'b0;
            rstate_q  <= R_READ;
          end
        end
        R_READ: begin
          rvalid_q <= 1'b1;
          rresp_q  <= r_inrange ? C_RESP_OKAY : C_RESP_SLVERR;
          rd_ok_q  <= r_inrange;
          rstate_q <= R_RESP;
        end
        R_RESP: begin
          if (i_axi_rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rstate_q  <= R_IDLE;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  // Processor side: remember lane select, range and dropped-write pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mc_ok_q   <= 1'b0;
      mc_sel_q  <= 2'b00;
      mc_coll_q <= 1'b0;
    end else begin
      mc_ok_q   <= mc_inrange;
      mc_sel_q  <= i_mc_addr[1:0];
      mc_coll_q <= coll;
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_lane
    axi4_lite_dpram_lane #(
      .L_DEPTH_WORDS(L_DEPTH_WORDS)
    ) u_lane (
      .i_clk     (i_clk),
      .i_a_we    (w_commit & wstrb_q[k]),
      .i_a_waddr (aw_word_q[IW-1:0]),
      .i_a_wdata (wdata_q[8*k +: 8]),
      .i_a_re    (r_re),
      .i_a_raddr (ar_word_q[IW-1:0]),
      .o_a_rdata (a_rdata[8*k +: 8]),
      .i_b_we    (mc_wr_ok & ~coll & (i_mc_addr[1:0] == 2'(k))),
      .i_b_addr  (mc_word[IW-1:0]),
      .i_b_wdata (i_mc_wdata),
      .o_b_rdata (b_rdata[k])
    );
  end

  assign o_axi_awready  = awready_q & ~i_rst;
  assign o_axi_wready   = wready_q & ~i_rst;
  assign o_axi_arready  = arready_q & ~i_rst;
  assign o_axi_bvalid   = bvalid_q & ~i_rst;
  assign o_axi_rvalid   = rvalid_q & ~i_rst;
  assign o_axi_bresp    = bresp_q;
  assign o_axi_rresp    = rresp_q;
  assign o_axi_rdata    = rd_ok_q ? a_rdata : 32'h0;
  assign o_mc_rdata     = mc_ok_q ? b_rdata[mc_sel_q] : 8'h00;
  assign o_mc_axi_wr    = mc_axi_wr_q;
  assign o_mc_axi_waddr = mc_axi_waddr_q;
  assign o_mc_collision = mc_coll_q;

endmodule

// File: tb/tb_axi4_lite_slave_sc_dpram.sv
// Directed bench for the AXI4-Lite byte RAM slave (16-word instance).
// Each step drives inputs after the edge and checks outputs 1 time unit later.
module tb_axi4_lite_slave_sc_dpram;

  logic        clk, rst;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [6:0]  awaddr, araddr, mc_addr, mc_waddr;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic        mc_wr, mc_axi_wr, mc_coll;
  logic [7:0]  mc_wdata, mc_rdata;

  int checks = 0;
  int failures = 0;

  logic [1:0]  resp;
  logic        pulse;
  logic [31:0] rv;
  logic [7:0]  bv;

  axi4_lite_slave_sc_dpram #(
    .L_ADDR_WIDTH (7),
    .L_DEPTH_WORDS(16)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_axi_awvalid (awvalid),
    .o_axi_awready (awready),
    .i_axi_awaddr  (awaddr),
    .i_axi_wvalid  (wvalid),
    .o_axi_wready  (wready),
    .i_axi_wdata   (wdata),
    .i_axi_wstrb   (wstrb),
    .o_axi_bvalid  (bvalid),
    .i_axi_bready  (bready),
    .o_axi_bresp   (bresp),
    .i_axi_arvalid (arvalid),
    .o_axi_arready (arready),
    .i_axi_araddr  (araddr),
    .o_axi_rvalid  (rvalid),
    .i_axi_rready  (rready),
    .o_axi_rdata   (rdata),
    .o_axi_rresp   (rresp),
    .i_mc_addr     (mc_addr),
    .i_mc_wr       (mc_wr),
    .i_mc_wdata    (mc_wdata),
    .o_mc_rdata    (mc_rdata),
    .o_mc_axi_wr   (mc_axi_wr),
    .o_mc_axi_waddr(mc_waddr),
    .o_mc_collision(mc_coll)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d,
                    input logic [3:0] s, output logic [1:0] r,
                    output logic p);
    int n;
    awvalid = 1; awaddr = a; wvalid = 1; wdata = d; wstrb = s;
    tick();
    awvalid = 0; wvalid = 0;
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    chk("wr_bvalid", 32'(bvalid), 1);
    r = bresp; p = mc_axi_wr;
    bready = 1; tick(); bready = 0;
  endtask

  task automatic rd(input logic [6:0] a, output logic [31:0] d,
                    output logic [1:0] r);
    int n;
    arvalid = 1; araddr = a;
    tick();
    arvalid = 0;
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    chk("rd_rvalid", 32'(rvalid), 1);
    d = rdata; r = rresp;
    rready = 1; tick(); rready = 0;
  endtask

  task automatic mcrd(input logic [6:0] a, output logic [7:0] b);
    mc_addr = a;
    tick();
    b = mc_rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; awvalid = 0; awaddr = '0; wvalid = 0; wdata = '0;
    wstrb = '0; bready = 0; arvalid = 0; araddr = '0; rready = 0;
    mc_addr = '0; mc_wr = 0; mc_wdata = '0;
    tick(); tick();
    chk("rst_rdy_low", 32'({awready, wready, arready}), 0);
    chk("rst_valid_low", 32'({bvalid, rvalid}), 0);
    chk("rst_mc_rdata", 32'(mc_rdata), 0);
    rst = 0;
    #1;
    chk("rel_rdy", 32'({awready, wready, arready}), 32'h7);
    chk("rel_valid", 32'({bvalid, rvalid}), 0);
    chk("rel_resp", 32'({bresp, rresp}), 0);
    chk("rel_rdata", rdata, 0);
    chk("rel_mc", 32'({mc_rdata, mc_axi_wr, mc_waddr, mc_coll}), 0);

    // 1: AW then W three cycles later, partial strobe
    wr(7'h0C, 32'h44332211, 4'hF, resp, pulse);
    chk("t1_pre_resp", 32'(resp), 0);
    chk("t1_pre_pulse", 32'(pulse), 1);
    awvalid = 1; awaddr = 7'h0C;
    tick();
    chk("t1_awready_drop", 32'(awready), 0);
    chk("t1_wready_hold", 32'(wready), 1);
    awvalid = 0;
    tick(); tick();
    wvalid = 1; wdata = 32'h0F0E0D0C; wstrb = 4'b0011;
    tick();
    wvalid = 0;
    chk("t1_bvalid_c4", 32'(bvalid), 0);
    tick();
    chk("t1_bvalid_c5", 32'(bvalid), 1);
    chk("t1_bresp", 32'(bresp), 0);
    chk("t1_mc_wr", 32'(mc_axi_wr), 1);
    chk("t1_mc_waddr", 32'(mc_waddr), 32'h0C);
    bready = 1; tick(); bready = 0;
    chk("t1_bvalid_done", 32'(bvalid), 0);
    chk("t1_mc_wr_end", 32'(mc_axi_wr), 0);
    chk("t1_rdy_back", 32'({awready, wready}), 32'h3);
    mcrd(7'h0C, bv); chk("t1_b0C", 32'(bv), 32'h0C);
    mcrd(7'h0D, bv); chk("t1_b0D", 32'(bv), 32'h0D);
    mcrd(7'h0E, bv); chk("t1_b0E", 32'(bv), 32'h33);
    mcrd(7'h0F, bv); chk("t1_b0F", 32'(bv), 32'h44);

    // 2: read-first when AR and AW/W hit word 4 together
    wr(7'h10, 32'hAABBCCDD, 4'hF, resp, pulse);
    arvalid = 1; araddr = 7'h10;
    awvalid = 1; awaddr = 7'h10;
    wvalid = 1; wdata = 32'h13121110; wstrb = 4'hF;
    tick();
    arvalid = 0; awvalid = 0; wvalid = 0;
    mc_addr = 7'h10;
    tick();
    chk("t2_rvalid", 32'(rvalid), 1);
    chk("t2_bvalid", 32'(bvalid), 1);
    chk("t2_rdata_old", rdata, 32'hAABBCCDD);
    chk("t2_mc_old", 32'(mc_rdata), 32'hDD);
    rready = 1; bready = 1; tick(); rready = 0; bready = 0;
    rd(7'h10, rv, resp);
    chk("t2_rdata_new", rv, 32'h13121110);
    mcrd(7'h13, bv); chk("t2_mc_new", 32'(bv), 32'h13);

    // 3: out-of-range accesses at 4*depth
    wr(7'h00, 32'hCAFEF00D, 4'hF, resp, pulse);
    wr(7'h40, 32'hDEADBEEF, 4'hF, resp, pulse);
    chk("t3_bresp", 32'(resp), 32'h2);
    chk("t3_no_pulse", 32'(pulse), 0);
    rd(7'h40, rv, resp);
    chk("t3_rdata", rv, 0);
    chk("t3_rresp", 32'(resp), 32'h2);
    rd(7'h00, rv, resp);
    chk("t3_word0", rv, 32'hCAFEF00D);
    chk("t3_word0_resp", 32'(resp), 0);
    mc_addr = 7'h40; mc_wr = 1; mc_wdata = 8'h77;
    tick();
    mc_wr = 0;
    chk("t3_mc_oor", 32'(mc_rdata), 0);
    mcrd(7'h00, bv); chk("t3_mc_b00", 32'(bv), 32'h0D);

    // 4: same-byte collision, then neighbouring byte
    awvalid = 1; awaddr = 7'h10; wvalid = 1;
    wdata = 32'h00000055; wstrb = 4'b0001;
    tick();
    awvalid = 0; wvalid = 0;
    mc_wr = 1; mc_addr = 7'h10; mc_wdata = 8'hAA;
    tick();
    mc_wr = 0;
    chk("t4_coll", 32'(mc_coll), 1);
    chk("t4_waddr", 32'(mc_waddr), 32'h10);
    bready = 1; tick(); bready = 0;
    chk("t4_coll_end", 32'(mc_coll), 0);
    mcrd(7'h10, bv); chk("t4_b10", 32'(bv), 32'h55);
    awvalid = 1; awaddr = 7'h10; wvalid = 1;
    wdata = 32'h00000055; wstrb = 4'b0001;
    tick();
    awvalid = 0; wvalid = 0;
    mc_wr = 1; mc_addr = 7'h11; mc_wdata = 8'hAA;
    tick();
    mc_wr = 0;
    chk("t4_nocoll", 32'(mc_coll), 0);
    bready = 1; tick(); bready = 0;
    chk("t4_nocoll2", 32'(mc_coll), 0);
    mcrd(7'h10, bv); chk("t4_b10b", 32'(bv), 32'h55);
    mcrd(7'h11, bv); chk("t4_b11", 32'(bv), 32'hAA);
    rd(7'h10, rv, resp);
    chk("t4_word", rv, 32'h1312AA55);

    // 5: hold bready/rready low with new requests pending
    awvalid = 1; awaddr = 7'h20; wvalid = 1;
    wdata = 32'h12345678; wstrb = 4'hF;
    arvalid = 1; araddr = 7'h10;
    tick();
    wvalid = 0; awaddr = 7'h24; araddr = 7'h20;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("t5_hold", 32'({bvalid, rvalid, awready, wready, arready}),
          32'h18);
      chk("t5_rdata", rdata, 32'h1312AA55);
      tick();
    end
    awvalid = 0; arvalid = 0;
    bready = 1; rready = 1; tick(); bready = 0; rready = 0;
    chk("t5_release", 32'({bvalid, rvalid, awready, wready, arready}),
        32'h07);
    rd(7'h20, rv, resp);
    chk("t5_word8", rv, 32'h12345678);

    // 6: reset while the write response is pending
    awvalid = 1; awaddr = 7'h28; wvalid = 1;
    wdata = 32'h0BADF00D; wstrb = 4'hF;
    tick();
    awvalid = 0; wvalid = 0;
    tick();
    chk("t6_bvalid", 32'(bvalid), 1);
    rst = 1;
    tick();
    chk("t6_bvalid_rst", 32'(bvalid), 0);
    rst = 0;
    #1;
    chk("t6_rdy", 32'({awready, wready, arready}), 32'h7);
    chk("t6_bvalid_rel", 32'(bvalid), 0);
    rd(7'h28, rv, resp);
    chk("t6_committed", rv, 32'h0BADF00D);
    rd(7'h10, rv, resp);
    chk("t6_prior", rv, 32'h1312AA55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
